// File: rtl/iq_retire_pkg.sv
// Shared constants, types and helpers for the issue-queue retirement stage.
// The commit slot record is the same shape the vreg/vmem commit ports consume.
package iq_retire_pkg;

    localparam int IQ_DEPTH = 8;
    localparam int PTR_W    = $clog2(IQ_DEPTH);
    localparam int RETIRE_W = 2;
    localparam int CNT_W    = 32;

    typedef logic [PTR_W-1:0]    ptr_t;
    typedef logic [IQ_DEPTH-1:0] mask_t;

    typedef struct packed {
        logic valid;
        logic is_mem;
        ptr_t pos;
    } commit_slot_t;

    // Head-relative distance; the pointer width makes the subtraction wrap mod IQ_DEPTH.
    function automatic ptr_t rel_dist(input ptr_t pos, input ptr_t head);
        return ptr_t'(pos - head);
    endfunction

endpackage

// File: rtl/iq_age_mask.sv
// Thermometer mask of every entry strictly younger than i_pos, with age
// measured from i_head and wrapping around the queue.
module iq_age_mask
    import iq_retire_pkg::*;
(
    input  ptr_t  i_head,
    input  ptr_t  i_pos,
    output mask_t o_younger
);

    always_comb begin
        // NOTE: default first so every path assigns the output and no latch is inferred.
        o_younger = '0;
        for (int i = 0; i < IQ_DEPTH; i++) begin
            o_younger[i] = rel_dist(ptr_t'(i), i_head) > rel_dist(i_pos, i_head);
        end
    end

endmodule

// File: rtl/iq_retire.sv
// In-order retirement: commits up to two consecutive finished entries per
// cycle from the head, at most one store, with flush squash and a guard
// against re-retiring entries the queue has not cleared yet.
module iq_retire
    import iq_retire_pkg::*;
(
    input  logic                clk,
    input  logic                nrst,
    input  logic [IQ_DEPTH-1:0] validbit,
    input  logic [IQ_DEPTH-1:0] finished,
    input  logic [IQ_DEPTH-1:0] is_mem,
    input  logic                mem_ready,
    input  logic                flush_req,
    input  logic [PTR_W-1:0]    flush_pos,
    output logic [PTR_W-1:0]    head_ptr,
    output logic [IQ_DEPTH-1:0] retire_mask,
    output logic [IQ_DEPTH-1:0] squash_mask,
    output logic [RETIRE_W-1:0] commit_valid,
    output logic [PTR_W-1:0]    commit_pos0,
    output logic [PTR_W-1:0]    commit_pos1,
    output logic                mem_commit,
    output logic [CNT_W-1:0]    retired_cnt
);

    ptr_t         r_head;
    mask_t        r_retire_mask;
    mask_t        r_squash_mask;
    commit_slot_t r_slot0;
    commit_slot_t r_slot1;
    logic [CNT_W-1:0] r_cnt;

    ptr_t         w_h0;
    ptr_t         w_h1;
    mask_t        w_younger;
    mask_t        w_valid;
    mask_t        w_squash;
    mask_t        w_ready;
    mask_t        w_retire_mask;
    commit_slot_t w_slot0;
    commit_slot_t w_slot1;
    logic [1:0]       w_n_ret;
    logic [CNT_W:0]   w_cnt_sum;

    iq_age_mask u_age_mask (
        .i_head    (r_head),
        .i_pos     (flush_pos),
        .o_younger (w_younger)
    );

    assign w_h0 = r_head;
    assign w_h1 = r_head + ptr_t'(1);

    // Entries retired last cycle are still valid in the queue for one more cycle.
    assign w_valid  = validbit & ~r_retire_mask;
    assign w_squash = flush_req ? (w_younger & w_valid) : '0;
    assign w_ready  = w_valid & ~w_squash & finished;

    always_comb begin
        w_slot0       = '0;
        w_slot1       = '0;
        w_retire_mask = '0;

        w_slot0.valid = w_ready[w_h0] & (~is_mem[w_h0] | mem_ready);
        w_slot1.valid = w_slot0.valid & w_ready[w_h1]
                      & ~(is_mem[w_h1] & (is_mem[w_h0] | ~mem_ready));

        if (w_slot0.valid) begin
            w_slot0.pos         = w_h0;
            w_slot0.is_mem      = is_mem[w_h0];
            w_retire_mask[w_h0] = 1'b1;
        end
        if (w_slot1.valid) begin
            w_slot1.pos         = w_h1;
            w_slot1.is_mem      = is_mem[w_h1];
            w_retire_mask[w_h1] = 1'b1;
        end
    end

    assign w_n_ret   = {1'b0, w_slot0.valid} + {1'b0, w_slot1.valid};
    assign w_cnt_sum = {1'b0, r_cnt} + {{(CNT_W-1){1'b0}}, w_n_ret};

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_head        <= '0;
            r_retire_mask <= '0;
            r_squash_mask <= '0;
            r_slot0       <= '0;
            r_slot1       <= '0;
            r_cnt         <= '0;
        end else begin
            r_head        <= r_head + ptr_t'(w_n_ret);
            r_retire_mask <= w_retire_mask;
            r_squash_mask <= w_squash;
            r_slot0       <= w_slot0;
            r_slot1       <= w_slot1;
            r_cnt         <= w_cnt_sum[CNT_W] ? '1 : w_cnt_sum[CNT_W-1:0];
        end
    end

    assign head_ptr     = r_head;
    assign retire_mask  = r_retire_mask;
    assign squash_mask  = r_squash_mask;
    assign commit_valid = {r_slot1.valid, r_slot0.valid};
    assign commit_pos0  = r_slot0.pos;
    assign commit_pos1  = r_slot1.pos;
    assign mem_commit   = r_slot0.is_mem | r_slot1.is_mem;
    assign retired_cnt  = r_cnt;

endmodule

// File: tb/tb_iq_retire.sv
// Self-checking bench for iq_retire: directed vector table, reset-in-flight
// sequence, then random traffic checked against a behavioural model.
module tb_iq_retire;

    typedef struct packed {
        logic [7:0] v;
        logic [7:0] f;
        logic [7:0] m;
        logic       mr;
        logic       fl;
        logic [2:0] fp;
    } stim_t;

    typedef struct packed {
        logic [1:0]  cv;
        logic [2:0]  p0;
        logic [2:0]  p1;
        logic [7:0]  rm;
        logic [7:0]  sq;
        logic        mc;
        logic [2:0]  hd;
        logic [31:0] cnt;
    } exp_t;

    typedef struct packed {
        stim_t s;
        exp_t  e;
    } vec_t;

    logic        clk;
    logic        nrst;
    logic [7:0]  validbit;
    logic [7:0]  finished;
    logic [7:0]  is_mem;
    logic        mem_ready;
    logic        flush_req;
    logic [2:0]  flush_pos;
    logic [2:0]  head_ptr;
    logic [7:0]  retire_mask;
    logic [7:0]  squash_mask;
    logic [1:0]  commit_valid;
    logic [2:0]  commit_pos0;
    logic [2:0]  commit_pos1;
    logic        mem_commit;
    logic [31:0] retired_cnt;

    int n_chk = 0;
    int n_err = 0;

    exp_t        sb[$];
    logic [2:0]  m_head;
    logic [7:0]  m_rmask;
    logic [31:0] m_cnt;

    iq_retire dut (
        .clk          (clk),
        .nrst         (nrst),
        .validbit     (validbit),
        .finished     (finished),
        .is_mem       (is_mem),
        .mem_ready    (mem_ready),
        .flush_req    (flush_req),
        .flush_pos    (flush_pos),
        .head_ptr     (head_ptr),
        .retire_mask  (retire_mask),
        .squash_mask  (squash_mask),
        .commit_valid (commit_valid),
        .commit_pos0  (commit_pos0),
        .commit_pos1  (commit_pos1),
        .mem_commit   (mem_commit),
        .retired_cnt  (retired_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, wanted %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic compare(input string tag, input exp_t e);
        check({tag, " commit_valid"}, 32'(commit_valid), 32'(e.cv));
        check({tag, " commit_pos0"},  32'(commit_pos0),  32'(e.p0));
        check({tag, " commit_pos1"},  32'(commit_pos1),  32'(e.p1));
        check({tag, " retire_mask"},  32'(retire_mask),  32'(e.rm));
        check({tag, " squash_mask"},  32'(squash_mask),  32'(e.sq));
        check({tag, " mem_commit"},   32'(mem_commit),   32'(e.mc));
        check({tag, " head_ptr"},     32'(head_ptr),     32'(e.hd));
        check({tag, " retired_cnt"},  retired_cnt,       e.cnt);
    endtask

    // Walks the queue in age order rather than evaluating per-slot equations.
    function automatic exp_t model(input stim_t s, input logic [2:0] hd,
                                   input logic [7:0] rmk, input logic [31:0] cnt);
        exp_t e;
        int   fd;
        int   taken;
        bit   store_used;
        e          = '0;
        fd         = (int'(s.fp) + 8 - int'(hd)) % 8;
        taken      = 0;
        store_used = 0;
        for (int d = 0; d < 8; d++) begin
            int idx = (int'(hd) + d) % 8;
            if (s.fl && d > fd && s.v[idx] && !rmk[idx]) e.sq[idx] = 1'b1;
        end
        for (int k = 0; k < 2; k++) begin
            int idx = (int'(hd) + k) % 8;
            bit ok  = s.v[idx] && !rmk[idx] && !e.sq[idx] && s.f[idx];
            if (ok && s.m[idx]) ok = s.mr && !store_used;
            if (!ok) break;
            if (k == 0) e.p0 = 3'(idx);
            else        e.p1 = 3'(idx);
            e.cv[k]    = 1'b1;
            e.rm[idx]  = 1'b1;
            if (s.m[idx]) begin
                store_used = 1;
                e.mc       = 1'b1;
            end
            taken++;
        end
        e.hd  = 3'((int'(hd) + taken) % 8);
        e.cnt = (cnt > 32'hFFFF_FFFF - 32'(taken)) ? 32'hFFFF_FFFF : cnt + 32'(taken);
        return e;
    endfunction

    task automatic apply(input string tag, input stim_t s, input exp_t e);
        exp_t got;
        validbit  = s.v;
        finished  = s.f;
        is_mem    = s.m;
        mem_ready = s.mr;
        flush_req = s.fl;
        flush_pos = s.fp;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        compare(tag, got);
        m_head  = got.hd;
        m_rmask = got.rm;
        m_cnt   = got.cnt;
    endtask

    task automatic apply_model(input string tag, input stim_t s);
        apply(tag, s, model(s, m_head, m_rmask, m_cnt));
    endtask

    function automatic vec_t mkv(input logic [7:0] v, f, m, input logic mr, fl, input logic [2:0] fp,
                                 input logic [1:0] cv, input logic [2:0] p0, p1,
                                 input logic [7:0] rm, sq, input logic mc,
                                 input logic [2:0] hd, input logic [31:0] cnt);
        vec_t r;
        r.s = '{v: v, f: f, m: m, mr: mr, fl: fl, fp: fp};
        r.e = '{cv: cv, p0: p0, p1: p1, rm: rm, sq: sq, mc: mc, hd: hd, cnt: cnt};
        return r;
    endfunction

    vec_t vec[19];

    initial begin
        stim_t s;

        //             v      f      m      mr    fl    fp   | cv    p0    p1    rm     sq     mc    hd    cnt
        vec[0]  = mkv(8'h03, 8'h03, 8'h00, 1'b1, 1'b0, 3'd0, 2'b11, 3'd0, 3'd1, 8'h03, 8'h00, 1'b0, 3'd2, 2);
        vec[1]  = mkv(8'h0C, 8'h08, 8'h00, 1'b1, 1'b0, 3'd0, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 1'b0, 3'd2, 2);
        vec[2]  = mkv(8'h04, 8'h04, 8'h04, 1'b0, 1'b0, 3'd0, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 1'b0, 3'd2, 2);
        vec[3]  = mkv(8'h04, 8'h04, 8'h04, 1'b0, 1'b0, 3'd0, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 1'b0, 3'd2, 2);
        vec[4]  = mkv(8'h04, 8'h04, 8'h04, 1'b0, 1'b0, 3'd0, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 1'b0, 3'd2, 2);
        vec[5]  = mkv(8'h04, 8'h04, 8'h04, 1'b1, 1'b0, 3'd0, 2'b01, 3'd2, 3'd0, 8'h04, 8'h00, 1'b1, 3'd3, 3);
        vec[6]  = mkv(8'h18, 8'h18, 8'h18, 1'b1, 1'b0, 3'd0, 2'b01, 3'd3, 3'd0, 8'h08, 8'h00, 1'b1, 3'd4, 4);
        vec[7]  = mkv(8'h18, 8'h18, 8'h18, 1'b1, 1'b0, 3'd0, 2'b01, 3'd4, 3'd0, 8'h10, 8'h00, 1'b1, 3'd5, 5);
        vec[8]  = mkv(8'h60, 8'h60, 8'h00, 1'b1, 1'b0, 3'd0, 2'b11, 3'd5, 3'd6, 8'h60, 8'h00, 1'b0, 3'd7, 7);
        vec[9]  = mkv(8'h81, 8'h81, 8'h00, 1'b1, 1'b0, 3'd0, 2'b11, 3'd7, 3'd0, 8'h81, 8'h00, 1'b0, 3'd1, 9);
        vec[10] = mkv(8'h02, 8'h02, 8'h00, 1'b1, 1'b0, 3'd0, 2'b01, 3'd1, 3'd0, 8'h02, 8'h00, 1'b0, 3'd2, 10);
        vec[11] = mkv(8'h7C, 8'h04, 8'h00, 1'b1, 1'b1, 3'd3, 2'b01, 3'd2, 3'd0, 8'h04, 8'h70, 1'b0, 3'd3, 11);
        vec[12] = mkv(8'h38, 8'h00, 8'h00, 1'b1, 1'b1, 3'd3, 2'b00, 3'd0, 3'd0, 8'h00, 8'h30, 1'b0, 3'd3, 11);
        vec[13] = mkv(8'h08, 8'h08, 8'h00, 1'b1, 1'b0, 3'd0, 2'b01, 3'd3, 3'd0, 8'h08, 8'h00, 1'b0, 3'd4, 12);
        vec[14] = mkv(8'h18, 8'h00, 8'h00, 1'b1, 1'b1, 3'd4, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 1'b0, 3'd4, 12);
        vec[15] = mkv(8'h30, 8'h30, 8'h20, 1'b0, 1'b0, 3'd0, 2'b01, 3'd4, 3'd0, 8'h10, 8'h00, 1'b0, 3'd5, 13);
        vec[16] = mkv(8'h30, 8'h30, 8'h20, 1'b1, 1'b0, 3'd0, 2'b01, 3'd5, 3'd0, 8'h20, 8'h00, 1'b1, 3'd6, 14);
        vec[17] = mkv(8'hC0, 8'hC0, 8'h80, 1'b1, 1'b0, 3'd0, 2'b11, 3'd6, 3'd7, 8'hC0, 8'h00, 1'b1, 3'd0, 16);
        vec[18] = mkv(8'h03, 8'h03, 8'h00, 1'b1, 1'b1, 3'd0, 2'b01, 3'd0, 3'd0, 8'h01, 8'h02, 1'b0, 3'd1, 17);

        nrst      = 1'b1;
        validbit  = '0;
        finished  = '0;
        is_mem    = '0;
        mem_ready = 1'b0;
        flush_req = 1'b0;
        flush_pos = '0;
        m_head    = '0;
        m_rmask   = '0;
        m_cnt     = '0;
        #1 nrst = 1'b0;
        #11;
        compare("reset", '0);
        nrst = 1'b1;

        for (int i = 0; i < 19; i++) begin
            apply($sformatf("vec%0d", i), vec[i].s, vec[i].e);
        end

        // Reset while a dual commit is pulsing: outputs must drop with no clock edge.
        s = '{v: 8'h06, f: 8'h06, m: 8'h00, mr: 1'b1, fl: 1'b0, fp: 3'd0};
        apply_model("pre_reset", s);
        check("pre_reset pulse present", 32'(commit_valid), 32'h3);
        nrst = 1'b0;
        #1;
        compare("async_reset", '0);
        validbit = '0;
        finished = '0;
        @(negedge clk);
        nrst    = 1'b1;
        m_head  = '0;
        m_rmask = '0;
        m_cnt   = '0;
        s = '{v: 8'h00, f: 8'h00, m: 8'h00, mr: 1'b1, fl: 1'b0, fp: 3'd0};
        apply("post_reset_idle0", s, '0);
        apply("post_reset_idle1", s, '0);
        s = '{v: 8'h01, f: 8'h01, m: 8'h00, mr: 1'b1, fl: 1'b0, fp: 3'd0};
        apply("post_reset_first", s,
              '{cv: 2'b01, p0: 3'd0, p1: 3'd0, rm: 8'h01, sq: 8'h00, mc: 1'b0, hd: 3'd1, cnt: 1});

        for (int i = 0; i < 300; i++) begin
            s.v  = 8'($urandom);
            s.f  = 8'($urandom) | 8'($urandom);
            s.m  = 8'($urandom) & 8'($urandom);
            s.mr = 1'($urandom_range(0, 1));
            s.fl = ($urandom_range(0, 5) == 0);
            s.fp = 3'($urandom);
            apply_model("rand", s);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
